adc_capture_ctrl: RTL
=====================

// Module: adc_capture_ctrl
// PURPOSE
//  Triggered snapshot sequencer for one ADC core's parallel signed-sample word (sign-converted path output).
//  Armed by control logic, waits for a trigger, writes a programmed number of ADC words into an internal RAM.
//  Flags completion, then lets a host-side reader fetch the words at random addresses.
//  Sits between the ADC sign-conversion stage and the register/readout interface.
// PARAMETERS
//  ADC_DATA_WIDTH  8   bits per sample
//  PATH_NUM        8   parallel samples per clock word (WORD_W = ADC_DATA_WIDTH*PATH_NUM)
//  ADDR_WIDTH      10  capture RAM address width; depth = 2**ADDR_WIDTH words
//  TIMEOUT_CYCLES  2**20  ARMED-state trigger timeout (used only with ADC_CAP_TIMEOUT_EN)
// PORTS
//  clk           in   1             system clock, all logic on rising edge
//  rst           in   1             asynchronous reset, active-high
//  adc_word_i    in   WORD_W        signed ADC word, path 0 in LSBs
//  adc_valid_i   in   1             adc_word_i valid this cycle
//  arm_i         in   1             one-cycle arm request
//  abort_i       in   1             one-cycle abort request
//  ack_i         in   1             host acknowledges DONE
//  trig_i        in   1             trigger, sampled only when adc_valid_i=1
//  cap_len_i     in   ADDR_WIDTH+1  words to capture; latched on accepted arm; 0 => full depth
//  rd_addr_i     in   ADDR_WIDTH    readout address
//  rd_data_o     out  WORD_W        RAM word at rd_addr_i, registered
//  state_o       out  2             0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//  wr_count_o    out  ADDR_WIDTH+1  words written in current/last capture
//  done_o        out  1             high while in DONE
//  timeout_o     out  1             sticky timeout flag (tied 0 without ADC_CAP_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values: state IDLE, state_o=0, wr_count_o=0, done_o=0, timeout_o=0, rd_data_o=0; RAM content not reset.
//  IDLE: arm_i=1 -> ARMED next cycle; latches len = (cap_len_i==0) ? 2**ADDR_WIDTH : min(cap_len_i, 2**ADDR_WIDTH); wr_count cleared.
//  ARMED: first cycle with adc_valid_i & trig_i -> that word written at addr 0, wr_count=1, go CAPTURE
//    (if len==1, go DONE directly). trig_i without adc_valid_i is ignored.
//  CAPTURE: every adc_valid_i=1 cycle writes adc_word_i at addr wr_count, wr_count+1; on the write making wr_count==len
//    -> DONE next cycle. adc_valid_i=0 cycles stall without writing. trig_i ignored.
//  DONE: done_o=1; ack_i -> IDLE; arm_i -> ARMED (re-arm, new len latched); arm_i and ack_i together -> arm wins.
//  arm_i in ARMED/CAPTURE ignored. Write address never wraps; no write occurs after wr_count==len.
//  abort_i in any state -> IDLE next cycle, beats arm_i/ack_i/trig_i same cycle; wr_count_o holds the count reached.
//  Write cycle aborted by abort_i still completes that one write.
//  Read: rd_data_o = RAM[rd_addr_i] one cycle after rd_addr_i presented, any state. Same-address read/write
//    in one cycle returns the OLD word (read-first). Unwritten addresses return previous contents.
//  rst mid-capture: immediate IDLE, all outputs to reset values; RAM content retained.
// CONFIGURATION
//  ADC_CAP_TIMEOUT_EN defined: cycle counter runs in ARMED; after TIMEOUT_CYCLES cycles without trigger
//    -> IDLE, timeout_o=1 (sticky until next accepted arm_i or rst). Counter cleared on entering ARMED.
//  Undefined: no counter; ARMED waits indefinitely; timeout_o tied 0.
// TESTING
//  1 rst; arm_i, cap_len_i=4; trig_i with ramp words 0x..01..05 -> RAM[0..3]=words 1..4, done_o 1 cycle after 4th write, wr_count_o=4.
//  2 cap_len_i=0, ADDR_WIDTH=4 -> exactly 16 writes, 17th valid word not written, state_o=3.
//  3 adc_valid_i toggled 1/0 during CAPTURE with len=8 -> 8 writes spread over 15 cycles, no gaps in addresses.
//  4 abort_i at wr_count=3 of len 8 -> IDLE next cycle, wr_count_o=3, done_o=0; arm_i+ack_i in DONE -> ARMED.
//  5 read addr 5 same cycle as write to addr 5 -> rd_data_o = old value, next read returns new value.
//  6 ADC_CAP_TIMEOUT_EN, TIMEOUT_CYCLES=16: arm, no trigger -> IDLE after 16 cycles, timeout_o=1; next arm clears it.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// adc_capture_ctrl
//
// Triggered snapshot sequencer for one ADC core's parallel sample word.
// Control logic arms the block. The block then waits for a trigger that
// arrives together with a valid ADC word. From that word on, it writes a
// programmed number of words into an internal RAM. When the capture is
// complete it raises done_o. A host-side reader can fetch any RAM word at
// any time through a registered read port.
//
// Optional feature (compile-time macro): ADC_CAP_TIMEOUT_EN
//   defined   : ARMED gives up after TIMEOUT_CYCLES cycles without a trigger,
//               returns to IDLE and sets the sticky timeout_o flag
//   undefined : ARMED waits indefinitely; timeout_o is tied low
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   adc_word_i   signed ADC word, path 0 in the LSBs
//   adc_valid_i  adc_word_i is valid this cycle
//   arm_i        one-cycle arm request (accepted in IDLE and DONE)
//   abort_i      one-cycle abort request, returns to IDLE from any state
//   ack_i        host acknowledge of DONE
//   trig_i       trigger, only honoured together with adc_valid_i
//   cap_len_i    words to capture, latched on an accepted arm; 0 = full depth
//   rd_addr_i    readout address
//   rd_data_o    RAM word at rd_addr_i, one cycle later (read-first)
//   state_o      0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   wr_count_o   words written in the current or last capture
//   done_o       high while in DONE
//   timeout_o    sticky trigger-timeout flag
// -----------------------------------------------------------------------------
module adc_capture_ctrl #(
    parameter int ADC_DATA_WIDTH = 8,
    parameter int PATH_NUM       = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADC_DATA_WIDTH*PATH_NUM-1:0] adc_word_i,
    input  logic                               adc_valid_i,
    input  logic                               arm_i,
    input  logic                               abort_i,
    input  logic                               ack_i,
    input  logic                               trig_i,
    input  logic [ADDR_WIDTH:0]                cap_len_i,
    input  logic [ADDR_WIDTH-1:0]              rd_addr_i,
    output logic [ADC_DATA_WIDTH*PATH_NUM-1:0] rd_data_o,
    output logic [1:0]                         state_o,
    output logic [ADDR_WIDTH:0]                wr_count_o,
    output logic                               done_o,
    output logic                               timeout_o
);

    localparam int WORD_W = ADC_DATA_WIDTH * PATH_NUM;
    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int CW     = ADDR_WIDTH + 1;

    // Full depth as a count value; it fits because counts are one bit wider
    // than addresses.
    localparam logic [CW-1:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state;
    logic [CW-1:0]       len;
    logic [CW-1:0]       wr_count;
    logic [CW-1:0]       wr_count_inc;
    logic [CW-1:0]       len_next;
    logic                done;
    logic                wr_en;
    logic [WORD_W-1:0]   rd_data;
    logic [WORD_W-1:0]   mem [DEPTH];

`ifdef ADC_CAP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
    logic          timeout;
`endif

    // A length of zero, or any value past the RAM depth, selects the full depth.
    always_comb begin
        len_next = cap_len_i;
        if (cap_len_i == '0 || cap_len_i > DEPTH_W) begin
            len_next = DEPTH_W;
        end
    end

    // An abort does not suppress a write already under way in CAPTURE.
    // In ARMED, an abort does suppress the write, because the abort beats the
    // trigger. The length guard makes sure that no write can happen once the
    // programmed count has been reached.
    always_comb begin
        wr_en = 1'b0;
        if (state == ST_ARMED) begin
            wr_en = adc_valid_i && trig_i && !abort_i;
        end else if (state == ST_CAPTURE) begin
            wr_en = adc_valid_i && (wr_count < len);
        end
    end

    assign wr_count_inc = wr_count + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len      <= DEPTH_W;
            wr_count <= '0;
            done     <= 1'b0;
`ifdef ADC_CAP_TIMEOUT_EN
            tmo_cnt  <= '0;
            timeout  <= 1'b0;
`endif
        end else if (abort_i) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            if (wr_en) begin
                wr_count <= wr_count_inc;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_i) begin
                        state    <= ST_ARMED;
                        len      <= len_next;
                        wr_count <= '0;
`ifdef ADC_CAP_TIMEOUT_EN
                        tmo_cnt  <= '0;
                        timeout  <= 1'b0;
`endif
                    end
                end

                ST_ARMED: begin
                    if (wr_en) begin
                        wr_count <= CW'(1);
                        if (len == CW'(1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
`ifdef ADC_CAP_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        state   <= ST_IDLE;
                        timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end

                ST_CAPTURE: begin
                    if (wr_en) begin
                        wr_count <= wr_count_inc;
                        if (wr_count_inc == len) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (arm_i) begin
                        state    <= ST_ARMED;
                        len      <= len_next;
                        wr_count <= '0;
                        done     <= 1'b0;
`ifdef ADC_CAP_TIMEOUT_EN
                        tmo_cnt  <= '0;
                        timeout  <= 1'b0;
`endif
                    end else if (ack_i) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // RAM contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_count[ADDR_WIDTH-1:0]] <= adc_word_i;
        end
    end

    // The read port samples the array before this cycle's write lands, so a
    // same-address read and write returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr_i];
        end
    end

    assign rd_data_o  = rd_data;
    assign state_o    = state;
    assign wr_count_o = wr_count;
    assign done_o     = done;

`ifdef ADC_CAP_TIMEOUT_EN
    assign timeout_o = timeout;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
